rom_fetch_ctrl: RTL

- Instruction-fetch sequencer for the 16-word, 32-bit instruction ROM. The ROM is a combinational read with an active-high enable.
- Owns the PC and drives the ROM address and enable.
- Registers each fetched word into an output stage and hands it to decode over a valid/ready handshake.
- Supports start, branch/jump redirect, halt, and end-of-ROM termination.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/fetch_out_reg.sv | 39 +++
 rtl/rom_fetch_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-path definitions: state encoding, widths, reset PC and the
// valid/ready "stage free" helper.
package cpu_pkg;

    localparam int INSTR_W     = 32;
    localparam int IMEM_ADDR_W = 4;
    localparam int RESET_PC    = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fetch_state_t;

    // The output stage can take a new word when it is empty or being emptied.
    function automatic logic stage_free(input logic valid, input logic ready);
        return (!valid) || ready;
    endfunction

endpackage

// File: rtl/fetch_out_reg.sv
// Valid/ready holding register for fetched instructions.
// flush has priority over load; with neither, the contents hold.
module fetch_out_reg #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              flush,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] pc
);

    // Holding register: flush empties, load captures, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            data  <= data;
            pc    <= pc;
        end else if (load) begin
            valid <= 1'b1;
            data  <= data_in;
            pc    <= pc_in;
        end else begin
            valid <= valid;
            data  <= data;
            pc    <= pc;
        end
    end

endmodule

// File: rtl/rom_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the combinational ROM and
// hands each fetched word to decode through a registered valid/ready stage.
module rom_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter int ADDR_W       = IMEM_ADDR_W,
    parameter int DATA_W       = INSTR_W,
    parameter int RESET_PC     = cpu_pkg::RESET_PC,
    parameter bit HALT_ON_WRAP = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              halt_req,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] START_PC  = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    fetch_state_t      state_r;
    logic [ADDR_W-1:0] pc_r;
    logic              busy_r;
    logic              done_r;
    logic              free_s;
    logic              last_s;
    logic              load_s;
    logic              flush_s;

    // ROM is read combinationally, so address and enable follow state and PC.
    assign rom_en   = (state_r == ST_FETCH);
    assign rom_addr = (state_r == ST_FETCH) ? pc_r : {ADDR_W{1'b0}};
    assign busy     = busy_r;
    assign done     = done_r;

    // Output-stage control: decide capture or flush for this cycle.
    always_comb begin
        free_s  = stage_free(instr_valid, instr_ready);
        last_s  = (pc_r == LAST_ADDR);
        load_s  = 1'b0;
        flush_s = 1'b0;
        case (state_r)
            ST_FETCH: begin
                if (halt_req) begin
                    flush_s = free_s;
                end else if (redirect_valid) begin
                    flush_s = 1'b1;
                end else if (free_s) begin
                    load_s = 1'b1;
                end else begin
                    load_s  = 1'b0;
                    flush_s = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (free_s) begin
                    flush_s = 1'b1;
                end else begin
                    flush_s = 1'b0;
                end
            end
            default: begin
                load_s  = 1'b0;
                flush_s = 1'b0;
            end
        endcase
    end

    // Fetch FSM and PC, with registered busy/done status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            pc_r    <= START_PC;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_r <= ST_FETCH;
                        pc_r    <= START_PC;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (halt_req) begin
                        state_r <= ST_DRAIN;
                    end else if (redirect_valid) begin
                        pc_r <= redirect_addr;
                    end else if (free_s) begin
                        if (last_s && HALT_ON_WRAP) begin
                            state_r <= ST_DRAIN;
                        end else begin
                            pc_r <= pc_r + ADDR_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (free_s) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    fetch_out_reg #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_out (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load_s),
        .flush  (flush_s),
        .data_in(rom_data),
        .pc_in  (pc_r),
        .valid  (instr_valid),
        .data   (instr),
        .pc     (instr_pc)
    );

endmodule
